// File: rtl/cpu_if_pkg.sv
// Shared types and default parameters for the CPU interface arbiter slice.
package cpu_if_pkg;

  localparam int unsigned ARB_NUM_REQ_DEFAULT        = 4;
  localparam int unsigned ARB_TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } cpu_op_e;

endpackage

// File: rtl/cpu_if_rr_picker.sv
// Combinational round-robin picker: first requesting index at or above rr_ptr,
// wrapping modulo NUM_REQ (exact for non-power-of-2 counts).
module cpu_if_rr_picker
  import cpu_if_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ_DEFAULT,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Candidate gi is the index gi positions past rr_ptr; the extra sum bit
  // holds up to 2*NUM_REQ-2 so the wrap is a single conditional subtract.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                          IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  always_comb begin
    winner_idx    = '0;
    winner_onehot = '0;
    valid         = |cand_hit;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) winner_idx = cand_idx[k];
    end
    if (valid) winner_onehot[winner_idx] = 1'b1;
  end

endmodule

// File: rtl/cpu_if_arbiter.sv
// Round-robin arbiter sharing one CPU interface controller among NUM_REQ requesters.
// Optional watchdog enabled by defining CPU_IF_ARB_TIMEOUT_EN.
module cpu_if_arbiter
  import cpu_if_pkg::*;
#(
  parameter int unsigned NUM_REQ        = ARB_NUM_REQ_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_write,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] req_err,
  output logic [NUM_REQ-1:0] grant,
  output logic               if_read,
  output logic               if_write,
  input  logic               if_ready,
  input  logic               if_access_complete,
  output logic               if_abort
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_reg, state_next;
  cpu_op_e            op_reg, op_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next, rr_ptr_inc;
  logic [NUM_REQ-1:0] req_any, pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               timeout_hit;

  assign req_any = req_read | req_write;

  cpu_if_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req           (req_any),
    .rr_ptr        (rr_ptr_reg),
    .winner_onehot (pick_onehot),
    .winner_idx    (pick_idx),
    .valid         (pick_valid)
  );

  assign rr_ptr_inc = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

`ifdef CPU_IF_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]   wait_cnt_reg;
  logic [NUM_REQ-1:0] err_reg;
  logic               abort_reg;
  logic               timeout_fire;

  // Counter is zero in the first ARB_WAIT cycle, so the watchdog fires after
  // exactly TIMEOUT_CYCLES wait cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ARB_ISSUE) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == ARB_WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  assign timeout_hit  = (state_reg == ARB_WAIT) &&
                        (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_fire = timeout_hit && !if_access_complete;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg   <= '0;
      abort_reg <= 1'b0;
    end else begin
      err_reg   <= timeout_fire ? grant_reg : '0;
      abort_reg <= timeout_fire;
    end
  end

  assign req_err  = err_reg;
  assign if_abort = abort_reg;
`else
  assign timeout_hit = 1'b0;
  assign req_err     = '0;
  assign if_abort    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ARB_IDLE;
      op_reg     <= OP_READ;
      grant_reg  <= '0;
      done_reg   <= '0;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      owner_reg  <= owner_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    grant_next  = grant_reg;
    owner_next  = owner_reg;
    rr_ptr_next = rr_ptr_reg;
    done_next   = '0;
    unique case (state_reg)
      ARB_IDLE: begin
        if (if_ready && pick_valid) begin
          state_next = ARB_ISSUE;
          grant_next = pick_onehot;
          owner_next = pick_idx;
          op_next    = req_write[pick_idx] ? OP_WRITE : OP_READ;
        end
      end
      ARB_ISSUE: state_next = ARB_WAIT;
      // if_ready is deliberately not looked at here: it lags the strobe.
      ARB_WAIT: begin
        if (if_access_complete || timeout_hit) begin
          state_next  = ARB_IDLE;
          grant_next  = '0;
          rr_ptr_next = rr_ptr_inc;
          if (if_access_complete) done_next = grant_reg;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign grant    = grant_reg;
  assign req_done = done_reg;
  assign if_read  = (state_reg == ARB_ISSUE) && (op_reg == OP_READ);
  assign if_write = (state_reg == ARB_ISSUE) && (op_reg == OP_WRITE);

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Scoreboard bench for cpu_if_arbiter: stimulus queues expected strobe/done/err
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_cpu_if_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 10;

  typedef enum logic [2:0] {EV_RD, EV_WR, EV_BOTH, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] req_read = '0;
  logic [3:0] req_write = '0;
  logic [3:0] req_done, req_err, grant;
  logic       if_read, if_write, if_abort;
  logic       if_ready = 1'b1;
  logic       if_access_complete = 1'b0;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  lat_cfg = 0;

  cpu_if_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .req_read           (req_read),
    .req_write          (req_write),
    .req_done           (req_done),
    .req_err            (req_err),
    .grant              (grant),
    .if_read            (if_read),
    .if_write           (if_write),
    .if_ready           (if_ready),
    .if_access_complete (if_access_complete),
    .if_abort           (if_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller stand-in: complete lat_cfg cycles after the strobe (0 = never).
  initial begin
    int cpl_cnt;
    cpl_cnt = 0;
    forever begin
      @(negedge clk);
      if ((if_read || if_write) && lat_cfg > 0) cpl_cnt = lat_cfg;
      @(posedge clk);
      #1;
      if (cpl_cnt > 0) begin
        cpl_cnt--;
        if_access_complete = (cpl_cnt == 0);
      end else begin
        if_access_complete = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic pop_cmp(input string name, input ev_kind_e kind, input logic [3:0] vec,
                         input logic side_ok);
    ev_t ev;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s unexpected: got %s vec=%b cycle %0d, expected nothing",
               name, kind.name(), vec, cyc);
    end else begin
      ev = exp_q.pop_front();
      if (ev.kind != kind || ev.vec !== vec || ev.cyc != cyc || !side_ok) begin
        n_fail++;
        $display("[TB] FAIL %s: got %s vec=%b cycle %0d side_ok=%0b, expected %s vec=%b cycle %0d",
                 name, kind.name(), vec, cyc, side_ok, ev.kind.name(), ev.vec, ev.cyc);
      end else begin
        $display("[TB] %s %s vec=%b cycle %0d ok", name, kind.name(), vec, cyc);
      end
    end
  endtask

  // Monitor: every presented output must match the head of the queue.
  initial begin
    ev_kind_e kind;
    forever begin
      @(negedge clk);
      if (if_read || if_write) begin
        kind = (if_read && if_write) ? EV_BOTH : (if_write ? EV_WR : EV_RD);
        pop_cmp("strobe", kind, grant, 1'b1);
      end
      if (req_done != 4'b0) pop_cmp("done", EV_DONE, req_done, grant == 4'b0);
      if (req_err != 4'b0 || if_abort)
        pop_cmp("err", EV_ERR, req_err, (grant == 4'b0) && if_abort);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a posedge with requests already driven; returns in the
  // cycle where done/err is expected so the caller can drop the request.
  task automatic run_txn(input int owner, input ev_kind_e sk, input int lat, input bit to_err);
    ev_t ev;
    int  c0, end_cyc;
    logic [3:0] oh;
    c0      = cyc;
    oh      = 4'b0001 << owner;
    lat_cfg = to_err ? 0 : lat;
    ev.kind = sk;
    ev.vec  = oh;
    ev.cyc  = c0 + 1;
    exp_q.push_back(ev);
    end_cyc = to_err ? c0 + 2 + TIMEOUT_CYCLES : c0 + 2 + lat;
    ev.kind = to_err ? EV_ERR : EV_DONE;
    ev.cyc  = end_cyc;
    exp_q.push_back(ev);
    tick(end_cyc - c0);
  endtask

  initial begin
    ev_t ev;
    int  c0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_if_read", if_read, 0);
    chk("reset_if_write", if_write, 0);
    chk("reset_req_done", req_done, 0);
    chk("reset_req_err", req_err, 0);
    chk("reset_if_abort", if_abort, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(1);

    // Single read from requester 2, completion 3 cycles after the strobe.
    req_read = 4'b0100;
    run_txn(2, EV_RD, 3, 1'b0);
    req_read = '0;
    tick(3);

    // Read and write together: write wins; minimum 1-cycle completion.
    req_read  = 4'b0001;
    req_write = 4'b0001;
    run_txn(0, EV_WR, 1, 1'b0);
    req_read  = '0;
    req_write = '0;
    tick(3);

    // Controller not ready: nothing may be granted.
    if_ready = 1'b0;
    req_read = 4'b1000;
    repeat (5) begin
      @(negedge clk);
      chk("notready_grant", grant, 0);
      chk("notready_strobe", {if_read, if_write}, 0);
    end
    @(posedge clk);
    #1 if_ready = 1'b1;
    run_txn(3, EV_RD, 2, 1'b0);
    req_read = '0;
    tick(3);

    // All four requesting continuously: order 0,1,2,3,0.
    req_read = 4'b1111;
    for (int i = 0; i < 5; i++) run_txn(i % 4, EV_RD, 2, 1'b0);
    req_read = '0;
    tick(3);

    // Reset during ARB_WAIT; afterwards rr_ptr is back at 0.
    req_read = 4'b0101;
    c0       = cyc;
    lat_cfg  = 0;
    ev.kind  = EV_RD;
    ev.vec   = 4'b0100;
    ev.cyc   = c0 + 1;
    exp_q.push_back(ev);
    tick(3);
    reset_n = 1'b0;
    #1;
    chk("midreset_grant", grant, 0);
    chk("midreset_strobe", {if_read, if_write}, 0);
    chk("midreset_done", req_done, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run_txn(0, EV_RD, 1, 1'b0);
    req_read = '0;
    tick(3);

`ifdef CPU_IF_ARB_TIMEOUT_EN
    req_read = 4'b0010;
    run_txn(1, EV_RD, 0, 1'b1);
    req_read = '0;
    tick(3);
    // Completion lands in the timeout cycle: completion wins.
    req_write = 4'b0010;
    run_txn(1, EV_WR, TIMEOUT_CYCLES, 1'b0);
    req_write = '0;
    tick(3);
`else
    // Without the watchdog a long access simply completes.
    req_write = 4'b0010;
    run_txn(1, EV_WR, TIMEOUT_CYCLES + 5, 1'b0);
    req_write = '0;
    tick(3);
`endif

    tick(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
